soc_system_gpio_bank: RTL and testbench
=======================================

Name: soc_system_gpio_bank

Overview:
Parametrised Avalon-MM GPIO bank. It is the successor to the single 8-bit output-only PIO slave.
- Adds per-bit direction control, atomic set/clear of the output register, and synchronised input readback.
- Adds per-bit edge capture with a maskable, level-sensitive interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA bridge and drives/samples board signals such as motor enables, LEDs and sensor ready lines.

Parameters:
WIDTH, 8, number of GPIO bits (1..32).
RESET_VALUE, 0, out_port value after reset (WIDTH bits).
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  read data, combinational from address; bits above WIDTH read 0
in_port  in  WIDTH  asynchronous board inputs
out_port  out  WIDTH  output data register
oe  out  WIDTH  per-bit output enable (= direction register)
irq  out  1  interrupt request, level, active-high

Behaviour:
Clocking and reset:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: out_port=RESET_VALUE, oe=0, irqmask=0, edgecapture=0, irq=0, synchroniser and in_prev=0, prime counter=0.

Write and read timing:
- A write occurs on a cycle with chipselect=1 and write_n=0. It takes effect at the next clk edge.
- Reads have zero wait states. readdata is a combinational mux of the current register state.

Register map (word addresses):
- 0 DATA: write loads out_port. Read returns per bit: oe ? out_port : in_sync.
- 1 DIRECTION: read/write; 1 = output.
- 2 IRQMASK: read/write.
- 3 EDGECAPTURE: read returns capture bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 4 OUTSET: out_port <= out_port | wdata. Reads 0.
- 5 OUTCLEAR: out_port <= out_port & ~wdata. Reads 0.
- 6, 7: writes ignored; reads 0.

Input path:
- in_port passes through a SYNC_STAGES flop chain; the last stage is in_sync.
- in_prev is in_sync delayed by one cycle.
- Edge vector: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = in_sync ^ in_prev. EDGE_TYPE selects which one is used.
- Edges are captured on all bits regardless of direction.

Priming after reset:
- A prime counter counts 0..SYNC_STAGES+1 after reset and saturates there.
- Edge capture is suppressed until the counter saturates. This prevents an input held high through reset from producing a spurious rising-edge capture.

Latency:
- in_port changes before clk edge k.
- in_sync reflects the change after edge k+SYNC_STAGES-1, so it is readable at DATA in the following cycle.
- The edgecapture bit is set at edge k+SYNC_STAGES.
- irq is combinational: irq = |(edgecapture & irqmask). It asserts in the same cycle the capture bit is set.

Boundary conditions:
- An edge detected in the same cycle as a write-1-clear of the same bit: set wins and the bit stays 1. Edges are never lost.
- Capture bits are sticky. Repeated edges leave the bit at 1.
- An IRQMASK write takes effect next cycle. Unmasking an already-set capture bit asserts irq immediately after the write edge.
- Changing DIRECTION does not alter out_port. out_port value and oe are independent.
- Reset asserted mid-operation (any cycle) returns all state to reset values at the next clk edge. This includes re-arming the prime counter.
- WIDTH<32: writedata[31:WIDTH] ignored; readdata[31:WIDTH]=0 for every address.

Test Plan:
1. Reset, then read all eight addresses -> DATA=0 (oe=0, inputs low), DIRECTION=0, IRQMASK=0, EDGECAPTURE=0, addresses 4..7=0; out_port=RESET_VALUE; irq=0.
2. Write DIRECTION=0xFF, DATA=0x0F, OUTSET=0x30, OUTCLEAR=0x03 -> out_port sequence 0x0F, 0x3F, 0x3C; DATA reads 0x3C; readdata[31:8]=0.
3. EDGE_TYPE=0, SYNC_STAGES=2, IRQMASK=0x01: raise in_port[0] before edge k -> EDGECAPTURE=0x01 and irq=1 from edge k+2; write 0x01 to address 3 -> irq=0 next cycle.
4. Hold in_port=0xFF through reset and release -> no capture bits set; DATA (oe=0) reads 0xFF after SYNC_STAGES cycles.
5. Arrange a rising edge on bit 2 in the same cycle as a write of 0x04 to EDGECAPTURE -> bit 2 remains 1.
6. EDGE_TYPE=2, pulse in_port[5] high for 3 cycles with mask=0 -> EDGECAPTURE=0x20, irq=0; then write IRQMASK=0x20 -> irq=1 one cycle later; assert reset mid-pulse -> all registers and irq return to reset values.

Source files
------------

// File: rtl/soc_system_gpio_bank_if.sv
// Avalon-MM slave bus bundle for the GPIO bank: word address, select,
// active-low write strobe, write data and combinational read data.
interface soc_system_gpio_bank_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/soc_system_gpio_bank.sv
// Parametrised GPIO bank: direction, atomic set/clear, synchronised input
// readback and per-bit sticky edge capture with a maskable level interrupt.
module soc_system_gpio_bank #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_TYPE   = 0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   soc_system_gpio_bank_if.slave bus,
   input  logic [WIDTH-1:0]      in_port,
   output logic [WIDTH-1:0]      out_port,
   output logic [WIDTH-1:0]      oe,
   output logic                  irq
);
   localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic [2:0]       r_prime;

   logic             w_wr;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic             w_primed;
   logic [31:0]      w_rdata;

   assign w_wr     = bus.chipselect & ~bus.write_n;
   assign w_wdata  = bus.writedata[WIDTH-1:0];
   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_primed = (r_prime == PRIME_DONE);
   assign w_clr    = (w_wr && bus.address == 3'd3) ? w_wdata : '0;

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign w_edge = w_sync & ~r_prev;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign w_edge = ~w_sync & r_prev;
      end else begin : g_any
         assign w_edge = w_sync ^ r_prev;
      end
   endgenerate

   // r_sync[0] is the stage nearest the pins; the last stage is the usable input
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync  <= '0;
         r_prev  <= '0;
         r_prime <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
         r_prev <= w_sync;
         if (!w_primed) r_prime <= r_prime + 3'd1;
      end
   end

   // A write-1-clear never beats a fresh edge on the same bit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out  <= RESET_VALUE;
         r_dir  <= '0;
         r_mask <= '0;
         r_cap  <= '0;
      end else begin
         r_cap <= (r_cap & ~w_clr) | (w_primed ? w_edge : '0);
         if (w_wr) begin
            case (bus.address)
               3'd0:    r_out  <= w_wdata;
               3'd1:    r_dir  <= w_wdata;
               3'd2:    r_mask <= w_wdata;
               3'd4:    r_out  <= r_out | w_wdata;
               3'd5:    r_out  <= r_out & ~w_wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         3'd0:    w_rdata[WIDTH-1:0] = (r_out & r_dir) | (w_sync & ~r_dir);
         3'd1:    w_rdata[WIDTH-1:0] = r_dir;
         3'd2:    w_rdata[WIDTH-1:0] = r_mask;
         3'd3:    w_rdata[WIDTH-1:0] = r_cap;
         default: w_rdata = '0;
      endcase
   end

   assign bus.readdata = w_rdata;
   assign out_port     = r_out;
   assign oe           = r_dir;
   assign irq          = |(r_cap & r_mask);
endmodule

// File: tb/tb_soc_system_gpio_bank.sv
// Randomised and directed bench for two GPIO bank instances (rising edge,
// 2 stages / any edge, 3 stages) against a cycle-level reference model.
module tb_soc_system_gpio_bank;
   localparam logic [7:0] RV = 8'h5A;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_port = '0;
   logic       b_cs = 1'b0;
   logic       b_wn = 1'b1;
   logic [2:0] b_addr = '0;
   logic [31:0] b_wd = '0;
   logic [7:0] out0, out1, oe0, oe1;
   logic       irq0, irq1;

   soc_system_gpio_bank_if bus0 ();
   soc_system_gpio_bank_if bus1 ();

   assign bus0.address = b_addr;  assign bus1.address = b_addr;
   assign bus0.chipselect = b_cs; assign bus1.chipselect = b_cs;
   assign bus0.write_n = b_wn;    assign bus1.write_n = b_wn;
   assign bus0.writedata = b_wd;  assign bus1.writedata = b_wd;

   soc_system_gpio_bank #(.WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port),
      .out_port(out0), .oe(oe0), .irq(irq0));
   soc_system_gpio_bank #(.WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port),
      .out_port(out1), .oe(oe1), .irq(irq1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference model: register values plus a per-instance history of sampled inputs
   int         m_s[2]  = '{2, 3};
   int         m_et[2] = '{0, 2};
   logic [7:0] m_out, m_dir, m_mask;
   logic [7:0] m_cap[2];
   logic [7:0] m_hist[2][5];
   int         m_edges[2];

   function automatic logic [7:0] m_in(int i);
      return m_hist[i][m_s[i]-1];
   endfunction

   function automatic logic [7:0] m_edge(int i);
      logic [7:0] cur, prv;
      cur = m_hist[i][m_s[i]-1];
      prv = m_hist[i][m_s[i]];
      if (m_et[i] == 0) return cur & ~prv;
      if (m_et[i] == 1) return ~cur & prv;
      return cur ^ prv;
   endfunction

   function automatic logic [31:0] m_rd(int i, logic [2:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         3'd0: r[7:0] = (m_out & m_dir) | (m_in(i) & ~m_dir);
         3'd1: r[7:0] = m_dir;
         3'd2: r[7:0] = m_mask;
         3'd3: r[7:0] = m_cap[i];
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_update();
      logic wr;
      wr = b_cs && !b_wn;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_cap[i] = '0;
            m_edges[i] = 0;
            for (int k = 0; k < 5; k++) m_hist[i][k] = '0;
         end else begin
            if (wr && b_addr == 3'd3) m_cap[i] = m_cap[i] & ~b_wd[7:0];
            if (m_edges[i] >= m_s[i] + 1) m_cap[i] = m_cap[i] | m_edge(i);
            for (int k = 4; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = in_port;
            m_edges[i]++;
         end
      end
      if (reset) begin
         m_out = RV; m_dir = '0; m_mask = '0;
      end else if (wr) begin
         case (b_addr)
            3'd0: m_out = b_wd[7:0];
            3'd1: m_dir = b_wd[7:0];
            3'd2: m_mask = b_wd[7:0];
            3'd4: m_out = m_out | b_wd[7:0];
            3'd5: m_out = m_out & ~b_wd[7:0];
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      #1;
      check({tag, "_rd0"}, bus0.readdata, m_rd(0, b_addr));
      check({tag, "_rd1"}, bus1.readdata, m_rd(1, b_addr));
      check({tag, "_out0"}, {24'h0, out0}, {24'h0, m_out});
      check({tag, "_out1"}, {24'h0, out1}, {24'h0, m_out});
      check({tag, "_oe0"}, {24'h0, oe0}, {24'h0, m_dir});
      check({tag, "_oe1"}, {24'h0, oe1}, {24'h0, m_dir});
      check({tag, "_irq0"}, {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask)});
      check({tag, "_irq1"}, {31'h0, irq1}, {31'h0, |(m_cap[1] & m_mask)});
   endtask

   task automatic write(input logic [2:0] a, input logic [31:0] d);
      b_cs = 1'b1; b_wn = 1'b0; b_addr = a; b_wd = d;
      $display("WR addr=%0d data=%08h", a, d);
      cycle();
      b_cs = 1'b0; b_wn = 1'b1;
      check_all("wr");
   endtask

   task automatic rd(input int i, input logic [2:0] a, output logic [31:0] v);
      b_cs = 1'b0; b_addr = a;
      #1;
      v = (i == 0) ? bus0.readdata : bus1.readdata;
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 8; a++) begin
         b_addr = 3'(a);
         check_all(tag);
      end
   endtask

   initial begin
      logic [31:0] v;
      // 1: reset state
      for (int n = 0; n < 3; n++) cycle();
      reset = 1'b0;
      read_all("t1");
      check("t1_out_rv", {24'h0, out0}, 32'h5A);
      check("t1_irq", {31'h0, irq0}, 32'h0);

      // 2: direction, load, set, clear
      write(3'd1, 32'hFFFF_FFFF);
      write(3'd0, 32'hFFFF_FF0F);
      check("t2_load", {24'h0, out0}, 32'h0F);
      write(3'd4, 32'h30);
      check("t2_set", {24'h0, out0}, 32'h3F);
      write(3'd5, 32'h03);
      check("t2_clr", {24'h0, out0}, 32'h3C);
      rd(0, 3'd0, v);
      check("t2_data", v, 32'h3C);

      // 3: rising edge latency and write-1-clear
      write(3'd1, 32'h0);
      write(3'd2, 32'h01);
      in_port = 8'h01;
      cycle(); check_all("t3a");
      check("t3_irq_k", {31'h0, irq0}, 32'h0);
      cycle(); check_all("t3b");
      check("t3_irq_k1", {31'h0, irq0}, 32'h0);
      cycle(); check_all("t3c");
      check("t3_irq_k2", {31'h0, irq0}, 32'h1);
      rd(0, 3'd3, v);
      check("t3_cap", v, 32'h01);
      write(3'd3, 32'h01);
      check("t3_irq_clr", {31'h0, irq0}, 32'h0);

      // 4: input held high through reset gives no capture
      in_port = 8'hFF;
      reset = 1'b1;
      cycle(); cycle();
      reset = 1'b0;
      cycle(); check_all("t4a");
      cycle(); check_all("t4b");
      rd(0, 3'd0, v);
      check("t4_data", v, 32'hFF);
      for (int n = 0; n < 5; n++) begin cycle(); check_all("t4c"); end
      rd(0, 3'd3, v);
      check("t4_cap0", v, 32'h0);
      rd(1, 3'd3, v);
      check("t4_cap1", v, 32'h0);

      // 5: edge coincident with its own clear
      in_port = 8'h00;
      for (int n = 0; n < 5; n++) cycle();
      write(3'd3, 32'hFF);
      in_port = 8'h04;
      cycle(); check_all("t5a");
      cycle(); check_all("t5b");
      write(3'd3, 32'h04);
      rd(0, 3'd3, v);
      check("t5_setwins", v, 32'h04);

      // 6: any-edge pulse, late unmask, reset mid-pulse
      for (int n = 0; n < 3; n++) cycle();
      write(3'd3, 32'hFF);
      write(3'd2, 32'h00);
      in_port = 8'h24;
      for (int n = 0; n < 3; n++) begin cycle(); check_all("t6a"); end
      in_port = 8'h04;
      for (int n = 0; n < 5; n++) begin cycle(); check_all("t6b"); end
      rd(1, 3'd3, v);
      check("t6_cap1", v, 32'h20);
      check("t6_irq_masked", {31'h0, irq1}, 32'h0);
      write(3'd2, 32'h20);
      check("t6_irq_unmask", {31'h0, irq1}, 32'h1);
      in_port = 8'h24;
      cycle();
      reset = 1'b1;
      cycle();
      read_all("t6r");
      check("t6_rst_irq", {31'h0, irq1}, 32'h0);
      check("t6_rst_out", {24'h0, out1}, 32'h5A);
      reset = 1'b0;

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(3) == 0) in_port = 8'($urandom);
         b_cs   = ($urandom_range(2) != 0);
         b_wn   = ($urandom_range(1) != 0);
         b_addr = 3'($urandom);
         b_wd   = $urandom;
         reset  = ($urandom_range(63) == 0);
         if (b_cs && !b_wn) $display("WR addr=%0d data=%08h", b_addr, b_wd);
         check_all("rnd");
         cycle();
      end
      reset = 1'b0;
      b_cs = 1'b0;
      check_all("end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
